// File: rtl/rcn_testregs_multi.sv
`timescale 1ns/1ps
// rcn_testregs_multi: RCN ring stop with NUM_CH progress/pass/fail register
// sets, a free-running cycle counter and an optional progress watchdog.
// Ports: clk, rst (sync, active-high), rcn_in/rcn_out (69-bit ring slot,
// 1-cycle registered), test_progress/test_pass/test_fail (32*NUM_CH),
// wdog_expired (sticky).
// Optional feature macro: RCN_TESTREGS_MULTI_WDOG_EN (watchdog present).
module rcn_testregs_multi #(
  parameter logic [23:0] ADDR_BASE  = 24'hFFFFC0,
  parameter int          NUM_CH     = 2,
  parameter logic [31:0] WDOG_RESET = 32'd1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [68:0]           rcn_in,
  output logic [68:0]           rcn_out,
  output logic [32*NUM_CH-1:0]  test_progress,
  output logic [32*NUM_CH-1:0]  test_pass,
  output logic [32*NUM_CH-1:0]  test_fail,
  output logic                  wdog_expired
);

  logic        hit;
  logic        wr_hit;
  logic [3:0]  mask;
  logic [1:0]  grp;
  logic [1:0]  ch;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] reload_rd;
  logic [31:0] ctrl_rd;

  logic [68:0] out_q, out_d;
  logic [31:0] cyc_q;
  logic [31:0] prog_q [NUM_CH];
  logic [31:0] prog_d [NUM_CH];
  logic [31:0] pass_q [NUM_CH];
  logic [31:0] pass_d [NUM_CH];
  logic [31:0] fail_q [NUM_CH];
  logic [31:0] fail_d [NUM_CH];

  assign hit    = rcn_in[68] & rcn_in[67] &
                  (rcn_in[55:38] == ADDR_BASE[23:6]);
  assign wr_hit = hit & rcn_in[66];
  assign mask   = rcn_in[59:56];
  assign grp    = rcn_in[37:36];
  assign ch     = rcn_in[35:34];
  assign wdata  = rcn_in[31:0];

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [31:0] nw,
    input logic [3:0]  m
  );
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) begin
      if (m[b]) res[8*b +: 8] = nw[8*b +: 8];
    end
    return res;
  endfunction

  // Read mux; absent channels fall through to 0.
  always_comb begin
    rdata = '0;
    unique case (grp)
      2'd0: begin
        for (int n = 0; n < NUM_CH; n++)
          if (ch == 2'(n)) rdata = prog_q[n];
      end
      2'd1: begin
        for (int n = 0; n < NUM_CH; n++)
          if (ch == 2'(n)) rdata = pass_q[n];
      end
      2'd2: begin
        for (int n = 0; n < NUM_CH; n++)
          if (ch == 2'(n)) rdata = fail_q[n];
      end
      2'd3: begin
        unique case (ch)
          2'd0: rdata = cyc_q;
          2'd1: rdata = reload_rd;
          2'd2: rdata = ctrl_rd;
          2'd3: rdata = {16'h5452, 8'd0, 8'(NUM_CH)};
        endcase
      end
    endcase
  end

  always_comb begin
    for (int n = 0; n < NUM_CH; n++) begin
      prog_d[n] = prog_q[n];
      pass_d[n] = pass_q[n];
      fail_d[n] = fail_q[n];
      if (wr_hit && ch == 2'(n)) begin
        if (grp == 2'd0) prog_d[n] = merge(prog_q[n], wdata, mask);
        if (grp == 2'd1) pass_d[n] = merge(pass_q[n], wdata, mask);
        if (grp == 2'd2) fail_d[n] = merge(fail_q[n], wdata, mask);
      end
    end
  end

  // Response reuses the request slot; writes echo their data.
  always_comb begin
    out_d = rcn_in;
    if (hit)
      out_d = {2'b10, rcn_in[66:32], rcn_in[66] ? wdata : rdata};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      cyc_q <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        prog_q[n] <= '0;
        pass_q[n] <= '0;
        fail_q[n] <= '0;
      end
    end else begin
      out_q <= out_d;
      cyc_q <= cyc_q + 32'd1;
      for (int n = 0; n < NUM_CH; n++) begin
        prog_q[n] <= prog_d[n];
        pass_q[n] <= pass_d[n];
        fail_q[n] <= fail_d[n];
      end
    end
  end

  assign rcn_out = out_q;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_out
    assign test_progress[32*n +: 32] = prog_q[n];
    assign test_pass[32*n +: 32]     = pass_q[n];
    assign test_fail[32*n +: 32]     = fail_q[n];
  end

`ifdef RCN_TESTREGS_MULTI_WDOG_EN
  logic [31:0] rld_q, rld_d;
  logic [31:0] wd_q, wd_d;
  logic        en_q, en_d;
  logic        exp_q, exp_d;
  logic        arm_q, arm_d;
  logic        wr_rld, wr_ctl, clr, load, expire, prog_evt;

  assign wr_rld = wr_hit & (grp == 2'd3) & (ch == 2'd1);
  assign wr_ctl = wr_hit & (grp == 2'd3) & (ch == 2'd2);

  always_comb begin
    prog_evt = 1'b0;
    for (int n = 0; n < NUM_CH; n++)
      if (wr_hit && grp == 2'd0 && ch == 2'(n) && mask != 4'd0)
        prog_evt = 1'b1;
  end

  // arm_q flags a fresh load of 0 so that a zero reload still expires
  // without a 1->0 transition.
  always_comb begin
    rld_d  = wr_rld ? merge(rld_q, wdata, mask) : rld_q;
    en_d   = (wr_ctl & mask[0]) ? wdata[1] : en_q;
    clr    = wr_ctl & mask[0] & wdata[0];
    load   = wr_rld | prog_evt | (~en_q & en_d);
    wd_d   = wd_q;
    arm_d  = 1'b0;
    if (load) begin
      wd_d  = rld_d;
      arm_d = (rld_d == 32'd0);
    end else if (en_q && wd_q != 32'd0) begin
      wd_d  = wd_q - 32'd1;
    end
    expire = ~load & en_q &
             ((wd_q == 32'd1) | ((wd_q == 32'd0) & arm_q));
    exp_d  = exp_q;
    if (expire)   exp_d = 1'b1;
    else if (clr) exp_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rld_q <= WDOG_RESET;
      wd_q  <= WDOG_RESET;
      en_q  <= 1'b0;
      exp_q <= 1'b0;
      arm_q <= 1'b0;
    end else begin
      rld_q <= rld_d;
      wd_q  <= wd_d;
      en_q  <= en_d;
      exp_q <= exp_d;
      arm_q <= arm_d;
    end
  end

  assign reload_rd    = rld_q;
  assign ctrl_rd      = {30'd0, en_q, exp_q};
  assign wdog_expired = exp_q;
`else
  assign reload_rd    = '0;
  assign ctrl_rd      = '0;
  assign wdog_expired = 1'b0;
`endif

endmodule

// File: tb/tb_rcn_testregs_multi.sv
`timescale 1ns/1ps
// tb_rcn_testregs_multi: directed, table-driven bench for the RCN
// test-status ring stop (NUM_CH=2), with hand-written watchdog sequences.
module tb_rcn_testregs_multi;

  localparam int          NCH = 2;
  localparam logic [31:0] WDR = 32'd1000000;

  logic              clk = 1'b0;
  logic              rst;
  logic [68:0]       rcn_in;
  logic [68:0]       rcn_out;
  logic [32*NCH-1:0] test_progress;
  logic [32*NCH-1:0] test_pass;
  logic [32*NCH-1:0] test_fail;
  logic              wdog_expired;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rcn_testregs_multi #(
    .ADDR_BASE  (24'hFFFFC0),
    .NUM_CH     (NCH),
    .WDOG_RESET (WDR)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rcn_in        (rcn_in),
    .rcn_out       (rcn_out),
    .test_progress (test_progress),
    .test_pass     (test_pass),
    .test_fail     (test_fail),
    .wdog_expired  (wdog_expired)
  );

  typedef struct {
    logic        v;
    logic        r;
    logic        w;
    logic [3:0]  m;
    logic [23:0] a;
    logic [31:0] d;
    logic        hit;
    logic [31:0] rd;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string name, input logic [68:0] act,
                     input logic [68:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [68:0] mk(
    input logic v, input logic r, input logic w,
    input logic [5:0] id, input logic [3:0] m,
    input logic [23:0] a, input logic [1:0] s, input logic [31:0] d);
    return {v, r, w, id, m, a[23:2], s, d};
  endfunction

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [23:0] a, output logic [31:0] d);
    rcn_in = mk(1'b1, 1'b1, 1'b0, 6'h2A, 4'hF, a, 2'd1, 32'h0);
    step(1);
    d = rcn_out[31:0];
    rcn_in = '0;
  endtask

  task automatic wr(input logic [23:0] a, input logic [31:0] d,
                    input logic [3:0] m);
    rcn_in = mk(1'b1, 1'b1, 1'b1, 6'h15, m, a, 2'd2, d);
    step(1);
    rcn_in = '0;
  endtask

  logic [31:0] d1, d2;
  logic [68:0] exp_o;

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 1'b0, 4'hF, 24'h000100, 32'h12345678, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 4'hF, 24'hFFFFC4, 32'h00000055, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 4'hF, 24'hFFFFC0, 32'hA5A5A5A5, 1'b0, 32'h0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 4'hF, 24'hFFFF80, 32'h0, 1'b0, 32'h0};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 4'hF, 24'hFFFFC4, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 4'hF, 24'hFFFFC4, 32'h0, 1'b1, 32'hDEADBEEF};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 4'hF, 24'hFFFFD0, 32'h11223344, 1'b1, 32'h11223344};
    tbl[7]  = '{1'b1, 1'b1, 1'b1, 4'h1, 24'hFFFFD0, 32'h000000AA, 1'b1, 32'h000000AA};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 4'hF, 24'hFFFFD0, 32'h0, 1'b1, 32'h112233AA};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 4'hF, 24'hFFFFC8, 32'h0, 1'b1, 32'h0};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 4'hF, 24'hFFFFC8, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 4'hF, 24'hFFFFC8, 32'h13579BDF, 1'b1, 32'h0};
    tbl[12] = '{1'b1, 1'b1, 1'b1, 4'hA, 24'hFFFFE0, 32'hCAFEF00D, 1'b1, 32'hCAFEF00D};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 4'hF, 24'hFFFFE0, 32'h0, 1'b1, 32'hCA00F000};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 4'h0, 24'hFFFFC0, 32'h99999999, 1'b1, 32'h99999999};
    tbl[15] = '{1'b1, 1'b1, 1'b0, 4'hF, 24'hFFFFC0, 32'h0, 1'b1, 32'h0};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 4'hF, 24'hFFFFFC, 32'h0, 1'b1, 32'h54520002};
    tbl[17] = '{1'b1, 1'b1, 1'b1, 4'hF, 24'hFFFFFC, 32'h0, 1'b1, 32'h0};
    tbl[18] = '{1'b1, 1'b1, 1'b0, 4'hF, 24'hFFFFFC, 32'h0, 1'b1, 32'h54520002};
    tbl[19] = '{1'b1, 1'b1, 1'b0, 4'hF, 24'hFFFFE4, 32'h0, 1'b1, 32'h0};

    rst = 1'b1;
    rcn_in = mk(1'b1, 1'b1, 1'b1, 6'h1, 4'hF, 24'hFFFFC0, 2'd0, 32'h5);
    step(3);
    chk("reset rcn_out", rcn_out, 69'h0);
    chk("reset progress", test_progress, 64'h0);
    chk("reset pass", test_pass, 64'h0);
    chk("reset fail", test_fail, 64'h0);
    chk("reset wdog", wdog_expired, 1'b0);
    rst = 1'b0;
    rcn_in = '0;
    step(1);

    for (int i = 0; i < 20; i++) begin
      rcn_in = mk(tbl[i].v, tbl[i].r, tbl[i].w, 6'(i), tbl[i].m,
                  tbl[i].a, 2'(i), tbl[i].d);
      if (tbl[i].hit)
        exp_o = mk(1'b1, 1'b0, tbl[i].w, 6'(i), tbl[i].m,
                   tbl[i].a, 2'(i), tbl[i].rd);
      else
        exp_o = rcn_in;
      step(1);
      chk($sformatf("vec%0d", i), rcn_out, exp_o);
    end
    rcn_in = '0;

    chk("progress regs", test_progress, {32'hDEADBEEF, 32'h0});
    chk("pass regs", test_pass, {32'h0, 32'h112233AA});
    chk("fail regs", test_fail, {32'h0, 32'hCA00F000});

    wr(24'hFFFFD4, 32'h5A5A5A5A, 4'hF);
    chk("pass1 same cycle", test_pass[63:32], 32'h5A5A5A5A);

    rd(24'hFFFFF0, d1);
    step(9);
    rd(24'hFFFFF0, d2);
    chk("cycle delta", d2 - d1, 32'd10);

`ifdef RCN_TESTREGS_MULTI_WDOG_EN
    rd(24'hFFFFF4, d1);
    chk("reload reset", d1, WDR);
    wr(24'hFFFFF4, 32'd5, 4'hF);
    wr(24'hFFFFF8, 32'h2, 4'hF);
    step(4);
    chk("wd before expiry", wdog_expired, 1'b0);
    step(1);
    chk("wd expiry", wdog_expired, 1'b1);
    step(3);
    chk("wd sticky", wdog_expired, 1'b1);
    wr(24'hFFFFF8, 32'h1, 4'hF);
    chk("wd clear", wdog_expired, 1'b0);
    step(10);
    chk("wd stays clear", wdog_expired, 1'b0);

    wr(24'hFFFFF8, 32'h2, 4'hF);
    for (int i = 0; i < 8; i++) begin
      step(2);
      chk($sformatf("wd kick%0d", i), wdog_expired, 1'b0);
      wr(24'hFFFFC0, 32'(i), 4'hF);
    end
    chk("kick progress", test_progress[31:0], 32'd7);
    step(4);
    chk("wd after kicks pre", wdog_expired, 1'b0);
    step(1);
    chk("wd after kicks", wdog_expired, 1'b1);

    wr(24'hFFFFF8, 32'h3, 4'hF);
    chk("wd clr2", wdog_expired, 1'b0);
    wr(24'hFFFFC4, 32'h1234, 4'hF);
    step(4);
    wr(24'hFFFFF4, 32'd5, 4'hF);
    chk("reload on 1->0", wdog_expired, 1'b0);
    step(4);
    chk("reload rerun pre", wdog_expired, 1'b0);
    step(1);
    chk("reload rerun", wdog_expired, 1'b1);

    wr(24'hFFFFF8, 32'h3, 4'hF);
    chk("wd clr3", wdog_expired, 1'b0);
    wr(24'hFFFFC0, 32'h1, 4'hF);
    step(4);
    wr(24'hFFFFF8, 32'h3, 4'hF);
    chk("set beats clear", wdog_expired, 1'b1);
    wr(24'hFFFFF8, 32'h3, 4'hF);
    chk("wd clr4", wdog_expired, 1'b0);
    step(7);
    chk("clear no reload", wdog_expired, 1'b0);

    wr(24'hFFFFF4, 32'd0, 4'hF);
    chk("zero reload pre", wdog_expired, 1'b0);
    step(1);
    chk("zero reload", wdog_expired, 1'b1);
    rd(24'hFFFFF8, d1);
    chk("ctrl read", d1, 32'h3);
`else
    rd(24'hFFFFF4, d1);
    chk("reload absent", d1, 32'h0);
    wr(24'hFFFFF4, 32'd5, 4'hF);
    wr(24'hFFFFF8, 32'h3, 4'hF);
    rd(24'hFFFFF8, d1);
    chk("ctrl absent", d1, 32'h0);
    step(20);
    chk("wdog tied", wdog_expired, 1'b0);
`endif

    rcn_in = mk(1'b1, 1'b1, 1'b1, 6'h7, 4'hF, 24'hFFFFD0, 2'd3, 32'h77);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    rcn_in = '0;
    chk("rst drop slot", rcn_out, 69'h0);
    chk("rst progress", test_progress, 64'h0);
    chk("rst pass", test_pass, 64'h0);
    chk("rst fail", test_fail, 64'h0);
    chk("rst wdog", wdog_expired, 1'b0);
    step(1);
    chk("rst no response", rcn_out, 69'h0);
    rd(24'hFFFFF0, d1);
    chk("cycle after rst", d1, 32'd1);
    rd(24'hFFFFF8, d1);
    chk("ctrl after rst", d1, 32'h0);
`ifdef RCN_TESTREGS_MULTI_WDOG_EN
    rd(24'hFFFFF4, d1);
    chk("reload after rst", d1, WDR);
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
